// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter that shares one SDRAM byte port
// between N_REQ requesters. Only one transaction is in flight at a time.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   rq_req/rq_we    per-requester request level and direction (1 = write)
//   rq_addr/rq_din  packed per-requester address (AW bits) and write byte
//   rq_done         one-cycle completion pulse to the granted requester
//   rq_dout         read byte, valid with rq_done, held until next completion
//   grant           one-hot current owner, zero when idle
//   sdram_*         request/handshake channel to the SDRAM controller
//   timeout_err     watchdog abort pulse
//
// Optional feature: define SDRAM_ARB_WATCHDOG_EN to abort a transaction whose
// sdram_done has not arrived after TIMEOUT cycles (rq_dout = 8'hFF on abort).
// Without it, timeout_err is tied to 0 and WAIT lasts indefinitely.

module sdram_port_arbiter #(
   parameter int unsigned N_REQ   = 3,
   parameter int unsigned AW      = 27,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      rq_req,
   input  logic [N_REQ-1:0]      rq_we,
   input  logic [N_REQ*AW-1:0]   rq_addr,
   input  logic [N_REQ*8-1:0]    rq_din,
   output logic [N_REQ-1:0]      rq_done,
   output logic [7:0]            rq_dout,
   output logic [N_REQ-1:0]      grant,
   input  logic                  sdram_ready,
   input  logic                  sdram_done,
   input  logic [7:0]            sdram_dout,
   output logic                  sdram_req,
   output logic                  sdram_we,
   output logic [AW-1:0]         sdram_addr,
   output logic [7:0]            sdram_din,
   output logic                  timeout_err
);

   localparam int unsigned PW = $clog2(N_REQ);

   // Elaboration-time sanity check on the parameter ranges.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
      $error("sdram_port_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [PW-1:0]   win, win_nxt;
   logic [PW-1:0]   sel;
   logic            sel_vld;
   logic            abort;

   logic               req_nxt, we_nxt;
   logic [AW-1:0]      addr_nxt;
   logic [7:0]         din_nxt, dout_nxt;
   logic [N_REQ-1:0]   grant_nxt, done_nxt;

   // Unpacked views of the packed per-requester buses.
   logic [AW-1:0] addr_a [N_REQ];
   logic [7:0]    din_a  [N_REQ];
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_a[g] = rq_addr[g*AW +: AW];
      assign din_a[g]  = rq_din[g*8 +: 8];
   end

   // First requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      logic [PW:0] cand;
      cand    = '0;
      sel     = '0;
      sel_vld = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
         if (!sel_vld && rq_req[cand[PW-1:0]]) begin
            sel_vld = 1'b1;
            sel     = cand[PW-1:0];
         end
      end
   end

`ifdef SDRAM_ARB_WATCHDOG_EN
   localparam int unsigned CW = $clog2(TIMEOUT);
   logic [CW-1:0] wd_cnt;

   // sdram_done on the limit cycle takes priority over the abort.
   assign abort = (state == WAIT) && !sdram_done && (wd_cnt == CW'(TIMEOUT - 1));

   // Counter is zero on the first WAIT cycle and counts each WAIT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= abort;
         if (state != WAIT) wd_cnt <= '0;
         else               wd_cnt <= wd_cnt + CW'(1);
      end
   end
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      win_nxt   = win;
      req_nxt   = sdram_req;
      we_nxt    = sdram_we;
      addr_nxt  = sdram_addr;
      din_nxt   = sdram_din;
      grant_nxt = grant;
      done_nxt  = '0;
      dout_nxt  = rq_dout;
      unique case (state)
         IDLE: begin
            if (sel_vld && sdram_ready) begin
               state_nxt = WAIT;
               win_nxt   = sel;
               req_nxt   = 1'b1;
               we_nxt    = rq_we[sel];
               addr_nxt  = addr_a[sel];
               din_nxt   = din_a[sel];
               grant_nxt = N_REQ'(1) << sel;
            end
         end
         WAIT: begin
            if (sdram_done || abort) begin
               state_nxt = GAP;
               req_nxt   = 1'b0;
               done_nxt  = grant;
               grant_nxt = '0;
               dout_nxt  = sdram_done ? sdram_dout : 8'hFF;
               ptr_nxt   = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
            end
         end
         // Bubble so a requester can drop its request after rq_done.
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         win        <= '0;
         sdram_req  <= 1'b0;
         sdram_we   <= 1'b0;
         sdram_addr <= '0;
         sdram_din  <= '0;
         grant      <= '0;
         rq_done    <= '0;
         rq_dout    <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         win        <= win_nxt;
         sdram_req  <= req_nxt;
         sdram_we   <= we_nxt;
         sdram_addr <= addr_nxt;
         sdram_din  <= din_nxt;
         grant      <= grant_nxt;
         rq_done    <= done_nxt;
         rq_dout    <= dout_nxt;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
// Define SDRAM_ARB_WATCHDOG_EN for both files to exercise the watchdog.

module tb_sdram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 27;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    rq_req, rq_we, rq_done, grant;
   logic [N*AW-1:0] rq_addr;
   logic [N*8-1:0]  rq_din;
   logic [7:0]      rq_dout, sdram_dout, sdram_din;
   logic            sdram_ready, sdram_done, sdram_req, sdram_we, timeout_err;
   logic [AW-1:0]   sdram_addr;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.N_REQ(N), .AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_din(rq_din),
      .rq_done(rq_done), .rq_dout(rq_dout), .grant(grant),
      .sdram_ready(sdram_ready), .sdram_done(sdram_done), .sdram_dout(sdram_dout),
      .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
      .sdram_din(sdram_din), .timeout_err(timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one in-flight transaction, rotating priority pointer.
   bit            m_busy, m_gap;
   int            m_ptr, m_win, m_cnt;
   logic          m_req, m_we, m_terr;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_din, m_dout;
   logic [N-1:0]  m_done, m_grant;

   task automatic model_step();
      if (reset) begin
         m_busy = 0; m_gap = 0; m_ptr = 0; m_win = 0; m_cnt = 0;
         m_req = 0; m_we = 0; m_terr = 0; m_addr = '0; m_din = '0; m_dout = '0;
         m_done = '0; m_grant = '0;
      end else begin
         m_done = '0;
         m_terr = 0;
         if (m_gap) begin
            m_gap = 0;
         end else if (m_busy) begin
            bit fin;
            bit tout;
            fin  = 0;
            tout = 0;
            if (sdram_done) fin = 1;
`ifdef SDRAM_ARB_WATCHDOG_EN
            else if (m_cnt == TO - 1) begin fin = 1; tout = 1; end
            else m_cnt++;
`endif
            if (fin) begin
               m_busy = 0; m_gap = 1; m_req = 0;
               m_done[m_win] = 1'b1;
               m_grant = '0;
               m_dout = tout ? 8'hFF : sdram_dout;
               m_terr = tout;
               m_ptr = (m_win + 1) % N;
            end
         end else if (rq_req != '0 && sdram_ready) begin
            for (int k = 0; k < N; k++) begin
               int w;
               w = (m_ptr + k) % N;
               if (rq_req[w]) begin m_win = w; break; end
            end
            m_busy = 1; m_cnt = 0; m_req = 1;
            m_we   = rq_we[m_win];
            m_addr = rq_addr[m_win*AW +: AW];
            m_din  = rq_din[m_win*8 +: 8];
            m_grant = '0;
            m_grant[m_win] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check("sdram_req",   sdram_req,   m_req);
      check("sdram_we",    sdram_we,    m_we);
      check("sdram_addr",  sdram_addr,  m_addr);
      check("sdram_din",   sdram_din,   m_din);
      check("grant",       grant,       m_grant);
      check("rq_done",     rq_done,     m_done);
      check("rq_dout",     rq_dout,     m_dout);
      check("timeout_err", timeout_err, m_terr);
   endtask

   // Inputs change at negedge; model and DUT both sample them at posedge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      rq_req[i] = 1'b1;
      rq_we[i]  = we;
      rq_addr[i*AW +: AW] = a;
      rq_din[i*8 +: 8]    = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int order[$];
      int lows, n, completions, pd;
      logic prev_req;

      reset = 1'b1; rq_req = '0; rq_we = '0; rq_addr = '0; rq_din = '0;
      sdram_ready = 1'b0; sdram_done = 1'b0; sdram_dout = '0;
      repeat (3) cycle();
      check("rst_sdram_req", sdram_req, 0);
      check("rst_grant", grant, 0);
      reset = 1'b0;
      sdram_ready = 1'b1;
      cycle();

      // Single write, done several cycles after the request.
      set_req(1, 1'b1, 27'h0123456, 8'hA5);
      cycle();
      check("wr_req", sdram_req, 1);
      check("wr_addr", sdram_addr, 27'h0123456);
      check("wr_din", sdram_din, 8'hA5);
      check("wr_we", sdram_we, 1);
      check("wr_grant", grant, 3'b010);
      repeat (4) begin
         cycle();
         check("wr_hold", {sdram_req, grant}, {1'b1, 3'b010});
      end
      sdram_done = 1'b1;
      cycle();
      sdram_done = 1'b0;
      rq_req = '0;
      check("wr_done", rq_done, 3'b010);
      check("wr_grant_clr", grant, 0);
      check("wr_req_clr", sdram_req, 0);
      cycle();
      check("wr_done_pulse", rq_done, 0);

      // Round robin with everybody requesting and immediate done.
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom), AW'($urandom), 8'($urandom));
      prev_req = 1'b0;
      lows = 0;
      for (int c = 0; c < 80 && order.size() < 6; c++) begin
         cycle();
         if (sdram_req && !prev_req) begin
            for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
            if (order.size() > 1) check("rr_gap", lows, 2);
            lows = 0;
         end else if (!sdram_req) lows++;
         prev_req = sdram_req;
         sdram_done = sdram_req;
      end
      check("rr_count", order.size(), 6);
      foreach (order[k]) check($sformatf("rr_order%0d", k), order[k], k % N);
      sdram_done = 1'b0;
      rq_req = '0;
      repeat (3) cycle();

      // Read data returned to requester 2 and held afterwards.
      set_req(2, 1'b0, AW'($urandom), 8'h00);
      cycle();
      check("rd_grant", grant, 3'b100);
      sdram_dout = 8'h3C;
      sdram_done = 1'b1;
      cycle();
      sdram_done = 1'b0;
      sdram_dout = 8'h81;
      rq_req = '0;
      check("rd_done", rq_done, 3'b100);
      check("rd_dout", rq_dout, 8'h3C);
      repeat (3) cycle();
      check("rd_hold", rq_dout, 8'h3C);

      // Backpressure: nothing issued while the controller is not ready.
      sdram_ready = 1'b0;
      set_req(0, 1'b1, AW'($urandom), 8'($urandom));
      repeat (10) begin
         cycle();
         check("bp_req", sdram_req, 0);
         check("bp_grant", grant, 0);
      end
      sdram_ready = 1'b1;
      cycle();
      check("bp_release", sdram_req, 1);
      sdram_done = 1'b1;
      cycle();
      sdram_done = 1'b0;
      rq_req = '0;
      repeat (2) cycle();

      // Reset during WAIT drops the transaction and restores the pointer.
      set_req(1, 1'b0, AW'($urandom), 8'($urandom));
      cycle();
      cycle();
      check("rw_inwait", sdram_req, 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rw_req", sdram_req, 0);
      check("rw_grant", grant, 0);
      check("rw_done", rq_done, 0);
      rq_req = '0;
      sdram_done = 1'b1;
      cycle();
      sdram_done = 1'b0;
      check("rw_stray_done", rq_done, 0);
      cycle();
      check("rw_stray_done2", rq_done, 0);
      set_req(0, 1'b0, AW'($urandom), 8'($urandom));
      set_req(2, 1'b0, AW'($urandom), 8'($urandom));
      cycle();
      check("rw_ptr0", grant, 3'b001);
      sdram_done = 1'b1;
      cycle();
      sdram_done = 1'b0;
      rq_req = '0;
      repeat (2) cycle();

`ifdef SDRAM_ARB_WATCHDOG_EN
      // Watchdog abort after TO WAIT cycles, then done on the limit cycle.
      set_req(0, 1'b0, AW'($urandom), 8'($urandom));
      cycle();
      n = 1;
      for (int c = 0; c < 40 && !timeout_err; c++) begin
         cycle();
         if (sdram_req) n++;
      end
      check("wd_wait_cycles", n, TO);
      check("wd_terr", timeout_err, 1);
      check("wd_done", rq_done, 3'b001);
      check("wd_dout", rq_dout, 8'hFF);
      rq_req = '0;
      repeat (2) cycle();
      set_req(0, 1'b0, AW'($urandom), 8'($urandom));
      cycle();
      repeat (TO - 1) cycle();
      check("wd_edge_inwait", sdram_req, 1);
      sdram_dout = 8'h5A;
      sdram_done = 1'b1;
      cycle();
      sdram_done = 1'b0;
      rq_req = '0;
      check("wd_edge_terr", timeout_err, 0);
      check("wd_edge_done", rq_done, 3'b001);
      check("wd_edge_dout", rq_dout, 8'h5A);
      repeat (2) cycle();
`endif

      // Randomized traffic; the model checks every cycle.
      completions = 0;
      pd = 4;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) pd = $urandom_range(2, 24);
         cycle();
         if (rq_done != '0) completions++;
         reset = ($urandom_range(0, 399) == 0);
         for (int i = 0; i < N; i++) begin
            if (rq_done[i]) rq_req[i] = 1'b0;
            else if (!rq_req[i] && $urandom_range(0, 3) == 0) rq_req[i] = 1'b1;
            rq_we[i] = 1'($urandom);
            rq_addr[i*AW +: AW] = AW'($urandom);
            rq_din[i*8 +: 8]    = 8'($urandom);
         end
         sdram_ready = ($urandom_range(0, 7) != 0);
         sdram_dout  = 8'($urandom);
         if (sdram_req) sdram_done = ($urandom_range(1, pd) == 1);
         else           sdram_done = ($urandom_range(0, 15) == 0);
      end
      check("progress", completions > 100, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
